multi_clock_divider: RTL and testbench

Parametrised multi-channel clock divider with shared speed control, the successor to the single-output divider. It sits between the system clock and the audio/sample-rate logic. It generates NUM_CH independent 50%-duty divided clocks plus one-cycle rising-edge tick strobes. All channels respond to speed-up, speed-down and speed-reset events. Divisor changes are glitch-free: they take effect only at a toggle boundary.

---
 rtl/clk_div_pkg.sv | 29 ++
 rtl/div_channel.sv | 56 +++++
 rtl/multi_clock_divider.sv | 118 +++++++++++
 tb/tb_multi_clock_divider.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types, default constants and clamp helper for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    SPD_NONE,
    SPD_UP,
    SPD_DOWN,
    SPD_RESET
  } speed_cmd_t;

  localparam int DEF_NUM_CH       = 2;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_DEFAULT_HALF = 16;
  localparam int DEF_STEP         = 4;
  localparam int DEF_MIN_HALF     = 4;
  localparam int DEF_MAX_HALF     = 64;

  // Operates on a 32-bit container so callers of any CNT_W up to 31 can share it.
  function automatic logic [31:0] clamp_half(input logic [31:0] v,
                                             input logic [31:0] lo,
                                             input logic [31:0] hi);
    logic [31:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: half-period counter, latched divisor, divided clock and rise strobe.
module div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_HALF = DEF_DEFAULT_HALF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] active,
  output logic             outclk,
  output logic             rise_tick
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic             outclk_q, outclk_d;
  logic             tick_q, tick_d;
  logic             wrap;

  assign wrap = (cnt_q == (cur_q - CNT_W'(1)));

  // The divisor is only sampled at a toggle, so a phase always runs its full length.
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    cur_d    = cur_q;
    outclk_d = outclk_q;
    tick_d   = 1'b0;
    if (wrap) begin
      cnt_d    = '0;
      cur_d    = active;
      outclk_d = ~outclk_q;
      tick_d   = ~outclk_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      cur_q    <= HALF_RST;
      outclk_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      outclk_q <= outclk_d;
      tick_q   <= tick_d;
    end
  end

  assign outclk    = outclk_q;
  assign rise_tick = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel 50%-duty clock divider with shared speed up/down/reset control
// and per-channel base half-period configuration.
module multi_clock_divider
  import clk_div_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_HALF = DEF_DEFAULT_HALF,
  parameter int STEP         = DEF_STEP,
  parameter int MIN_HALF     = DEF_MIN_HALF,
  parameter int MAX_HALF     = DEF_MAX_HALF,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              speed_up_event,
  input  logic              speed_down_event,
  input  logic              speed_reset_event,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [CNT_W-1:0]  half_rd,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] rise_tick
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W:0]   STEP_W   = (CNT_W+1)'(STEP);

  logic up_prev_q, dn_prev_q, rs_prev_q;
  logic up_edge, dn_edge, rs_edge;
  speed_cmd_t cmd;

  logic [NUM_CH-1:0][CNT_W-1:0] base_q, base_d;
  logic [NUM_CH-1:0][CNT_W-1:0] active_q, active_d;

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W:0] v);
    logic [31:0] c;
    c = clamp_half(32'(v), 32'(MIN_HALF), 32'(MAX_HALF));
    return c[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] step_up(input logic [CNT_W-1:0] a);
    logic [CNT_W:0] w;
    w = ({1'b0, a} > STEP_W) ? ({1'b0, a} - STEP_W) : '0;
    return clamp_cnt(w);
  endfunction

  function automatic logic [CNT_W-1:0] step_down(input logic [CNT_W-1:0] a);
    return clamp_cnt({1'b0, a} + STEP_W);
  endfunction

  assign up_edge = speed_up_event    & ~up_prev_q;
  assign dn_edge = speed_down_event  & ~dn_prev_q;
  assign rs_edge = speed_reset_event & ~rs_prev_q;

  always_comb begin
    cmd = SPD_NONE;
    if (rs_edge)                  cmd = SPD_RESET;
    else if (up_edge && !dn_edge) cmd = SPD_UP;
    else if (dn_edge && !up_edge) cmd = SPD_DOWN;
  end

  // Shared command first, then a cfg write replaces the result on its own channel.
  always_comb begin
    base_d   = base_q;
    active_d = active_q;
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (cmd)
        SPD_RESET: active_d[i] = base_q[i];
        SPD_UP:    active_d[i] = step_up(active_q[i]);
        SPD_DOWN:  active_d[i] = step_down(active_q[i]);
        SPD_NONE:  active_d[i] = active_q[i];
      endcase
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        base_d[i]   = clamp_cnt({1'b0, cfg_half});
        active_d[i] = clamp_cnt({1'b0, cfg_half});
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
      rs_prev_q <= 1'b0;
      base_q    <= {NUM_CH{HALF_RST}};
      active_q  <= {NUM_CH{HALF_RST}};
    end else begin
      up_prev_q <= speed_up_event;
      dn_prev_q <= speed_down_event;
      rs_prev_q <= speed_reset_event;
      base_q    <= base_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    half_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) half_rd = active_q[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_div_channel (
      .clk       (clk),
      .reset_n   (reset_n),
      .active    (active_q[g]),
      .outclk    (outclk[g]),
      .rise_tick (rise_tick[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider against a simple half-period model.
module tb_multi_clock_divider;

  localparam int STEP = 4;
  localparam int MINH = 4;
  localparam int MAXH = 64;
  localparam int HALF0 = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        up = 1'b0, dn = 1'b0, rs = 1'b0;
  logic        cfg_we = 1'b0;
  logic [0:0]  cfg_ch = 1'b0;
  logic [15:0] cfg_half = 16'd0;
  logic [15:0] half_rd;
  logic [1:0]  outclk, rise_tick;

  int checks = 0;
  int failures = 0;
  int m_base[2];
  int m_act[2];

  always #5 clk = ~clk;

  multi_clock_divider dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .speed_up_event    (up),
    .speed_down_event  (dn),
    .speed_reset_event (rs),
    .cfg_we            (cfg_we),
    .cfg_ch            (cfg_ch),
    .cfg_half          (cfg_half),
    .half_rd           (half_rd),
    .outclk            (outclk),
    .rise_tick         (rise_tick)
  );

  function automatic int clampi(int v);
    if (v < MINH) return MINH;
    if (v > MAXH) return MAXH;
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_base[c] = HALF0;
      m_act[c]  = HALF0;
    end
  endtask

  task automatic model_event(bit u, bit d, bit r);
    for (int c = 0; c < 2; c++) begin
      if (r) m_act[c] = m_base[c];
      else if (u && !d) m_act[c] = clampi(m_act[c] - STEP);
      else if (d && !u) m_act[c] = clampi(m_act[c] + STEP);
    end
  endtask

  task automatic press(bit u, bit d, bit r, int hold);
    @(negedge clk);
    up = u; dn = d; rs = r;
    repeat (hold) @(negedge clk);
    up = 1'b0; dn = 1'b0; rs = 1'b0;
    @(negedge clk);
    model_event(u, d, r);
  endtask

  task automatic cfg_write(int ch, int h, bit u, bit d, bit r);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch[0:0]; cfg_half = h[15:0];
    up = u; dn = d; rs = r;
    @(negedge clk);
    cfg_we = 1'b0; up = 1'b0; dn = 1'b0; rs = 1'b0;
    @(negedge clk);
    model_event(u, d, r);
    m_base[ch] = clampi(h);
    m_act[ch]  = m_base[ch];
  endtask

  task automatic read_half(input int c, output int v);
    cfg_ch = c[0:0];
    #1;
    v = int'(half_rd);
  endtask

  // Counts falling clk edges until rise_tick[ch] is seen; -1 if the budget expires.
  task automatic wait_rise(input int ch, input int budget, output int n);
    n = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (rise_tick[ch] === 1'b1) begin
        n = k;
        return;
      end
    end
    n = -1;
  endtask

  task automatic test_reset();
    int v, n;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (outclk !== 2'b00 || rise_tick !== 2'b00) begin
      failures++;
      $display("FAIL reset_outputs outclk=%b tick=%b expected 00/00", outclk, rise_tick);
    end
    for (int c = 0; c < 2; c++) begin
      read_half(c, v);
      checks++;
      if (v !== m_act[c]) begin
        failures++;
        $display("FAIL reset_half ch%0d actual=%0d expected=%0d", c, v, m_act[c]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_rise(0, 100, n);
    checks++;
    if (n !== HALF0) begin
      failures++;
      $display("FAIL first_rise actual=%0d expected=%0d", n, HALF0);
    end
    checks++;
    if (outclk[1] !== 1'b1) begin
      failures++;
      $display("FAIL first_rise_ch1 outclk1=%b expected 1", outclk[1]);
    end
  endtask

  task automatic test_free_run();
    int n, highs, ticks;
    for (int c = 0; c < 2; c++) begin
      wait_rise(c, 100, n);
      checks++;
      if (n !== 2 * HALF0 && c == 0) begin
        failures++;
        $display("FAIL free_period ch%0d actual=%0d expected=%0d", c, n, 2 * HALF0);
      end else if (c == 1 && n !== 2 * HALF0 - 0) begin
        failures++;
        $display("FAIL free_period ch%0d actual=%0d expected=%0d", c, n, 2 * HALF0);
      end
    end
    highs = 0; ticks = 0;
    for (int k = 0; k < 2 * HALF0; k++) begin
      @(negedge clk);
      if (outclk[0]) highs++;
      if (rise_tick[0]) ticks++;
    end
    checks++;
    if (highs !== HALF0 || ticks !== 1) begin
      failures++;
      $display("FAIL duty highs=%0d ticks=%0d expected %0d/1", highs, ticks, HALF0);
    end
  endtask

  task automatic test_speed_up_hold();
    int v, n;
    press(1, 0, 0, 3);
    for (int c = 0; c < 2; c++) begin
      read_half(c, v);
      checks++;
      if (v !== m_act[c] || v !== 12) begin
        failures++;
        $display("FAIL up_hold_half ch%0d actual=%0d expected=%0d", c, v, m_act[c]);
      end
    end
    wait_rise(0, 200, n);
    wait_rise(0, 200, n);
    checks++;
    if (n !== 2 * m_act[0]) begin
      failures++;
      $display("FAIL up_hold_period actual=%0d expected=%0d", n, 2 * m_act[0]);
    end
  endtask

  task automatic test_clamp();
    int v, n;
    repeat (5) press(1, 0, 0, 1);
    read_half(0, v);
    checks++;
    if (v !== MINH) begin
      failures++;
      $display("FAIL clamp_min actual=%0d expected=%0d", v, MINH);
    end
    wait_rise(0, 200, n);
    wait_rise(0, 200, n);
    checks++;
    if (n !== 2 * MINH) begin
      failures++;
      $display("FAIL clamp_min_period actual=%0d expected=%0d", n, 2 * MINH);
    end
    repeat (20) press(0, 1, 0, 2);
    read_half(1, v);
    checks++;
    if (v !== MAXH) begin
      failures++;
      $display("FAIL clamp_max actual=%0d expected=%0d", v, MAXH);
    end
    wait_rise(1, 300, n);
    wait_rise(1, 300, n);
    checks++;
    if (n !== 2 * MAXH) begin
      failures++;
      $display("FAIL clamp_max_period actual=%0d expected=%0d", n, 2 * MAXH);
    end
    press(0, 0, 1, 1);
    read_half(0, v);
    checks++;
    if (v !== HALF0) begin
      failures++;
      $display("FAIL speed_reset actual=%0d expected=%0d", v, HALF0);
    end
  endtask

  task automatic test_simultaneous();
    int v;
    press(1, 1, 0, 2);
    read_half(0, v);
    checks++;
    if (v !== 16) begin
      failures++;
      $display("FAIL up_down_together actual=%0d expected=16", v);
    end
    press(1, 0, 0, 1);
    press(1, 0, 1, 1);
    read_half(1, v);
    checks++;
    if (v !== 16 || v !== m_act[1]) begin
      failures++;
      $display("FAIL reset_with_up actual=%0d expected=16", v);
    end
  endtask

  task automatic test_cfg();
    int v0, v1, n;
    cfg_write(1, 40, 0, 0, 0);
    press(1, 0, 0, 1);
    read_half(0, v0); read_half(1, v1);
    checks++;
    if (v0 !== 12 || v1 !== 36) begin
      failures++;
      $display("FAIL cfg_then_up ch0=%0d ch1=%0d expected 12/36", v0, v1);
    end
    press(0, 0, 1, 1);
    read_half(0, v0); read_half(1, v1);
    checks++;
    if (v0 !== 16 || v1 !== 40) begin
      failures++;
      $display("FAIL cfg_then_reset ch0=%0d ch1=%0d expected 16/40", v0, v1);
    end
    cfg_write(1, 1, 0, 0, 0);
    read_half(1, v1);
    checks++;
    if (v1 !== MINH) begin
      failures++;
      $display("FAIL cfg_clamp actual=%0d expected=%0d", v1, MINH);
    end
    cfg_write(0, 60, 0, 1, 0);
    read_half(0, v0); read_half(1, v1);
    checks++;
    if (v0 !== 60 || v1 !== 8 || v0 !== m_act[0] || v1 !== m_act[1]) begin
      failures++;
      $display("FAIL cfg_with_event ch0=%0d ch1=%0d expected 60/8", v0, v1);
    end
    wait_rise(1, 200, n);
    wait_rise(1, 200, n);
    checks++;
    if (n !== 2 * m_act[1]) begin
      failures++;
      $display("FAIL cfg_period actual=%0d expected=%0d", n, 2 * m_act[1]);
    end
  endtask

  task automatic test_mid_phase();
    int n, n2, v;
    cfg_write(0, 16, 0, 0, 0);
    wait_rise(0, 300, n);
    wait_rise(0, 300, n);
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 4) up = 1'b1;
      if (k == 6) up = 1'b0;
      if (outclk[0] === 1'b0) begin
        n = k;
        break;
      end
    end
    model_event(1, 0, 0);
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL mid_phase_high actual=%0d expected=16", n);
    end
    n2 = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (outclk[0] === 1'b1) begin
        n2 = k;
        break;
      end
    end
    checks++;
    if (n2 !== m_act[0]) begin
      failures++;
      $display("FAIL mid_phase_low actual=%0d expected=%0d", n2, m_act[0]);
    end
    read_half(0, v);
    checks++;
    if (v !== 12) begin
      failures++;
      $display("FAIL mid_phase_half actual=%0d expected=12", v);
    end
  endtask

  task automatic test_reset_mid_phase();
    int n, v;
    wait_rise(0, 200, n);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (outclk !== 2'b00 || rise_tick !== 2'b00) begin
      failures++;
      $display("FAIL async_reset outclk=%b tick=%b expected 00/00", outclk, rise_tick);
    end
    read_half(1, v);
    checks++;
    if (v !== HALF0) begin
      failures++;
      $display("FAIL async_reset_half actual=%0d expected=%0d", v, HALF0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_rise(0, 100, n);
    checks++;
    if (n !== HALF0) begin
      failures++;
      $display("FAIL restart_first_rise actual=%0d expected=%0d", n, HALF0);
    end
    wait_rise(0, 100, n);
    checks++;
    if (n !== 2 * HALF0) begin
      failures++;
      $display("FAIL restart_period actual=%0d expected=%0d", n, 2 * HALF0);
    end
  endtask

  task automatic test_random();
    int v, n, ch, h;
    bit u, d, r;
    for (int it = 0; it < 40; it++) begin
      u = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        ch = $urandom_range(0, 1);
        h  = $urandom_range(0, 80);
        cfg_write(ch, h, u, d, r);
      end else begin
        press(u, d, r, $urandom_range(1, 3));
      end
      for (int c = 0; c < 2; c++) begin
        read_half(c, v);
        checks++;
        if (v !== m_act[c]) begin
          failures++;
          $display("FAIL random_half it%0d ch%0d actual=%0d expected=%0d", it, c, v, m_act[c]);
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      wait_rise(c, 300, n);
      wait_rise(c, 300, n);
      checks++;
      if (n !== 2 * m_act[c]) begin
        failures++;
        $display("FAIL random_period ch%0d actual=%0d expected=%0d", c, n, 2 * m_act[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_speed_up_hold();
    test_clamp();
    test_simultaneous();
    test_cfg();
    test_mid_phase();
    test_reset_mid_phase();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
